// File: rtl/fft_bfly_resp.sv
// fft_bfly_resp: radix-2 Q1.15 butterfly responder (X = A + W*B, Y = A - W*B).
// Define FFT_BFLY_OVF_STICKY_EN for a sticky ovf flag cleared by WR_W of zero.
module fft_bfly_resp #(
  parameter int SCALE = 1,
  parameter int ROUND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        ovf
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, ADD = 2'd2, RESP = 2'd3;
  localparam logic [2:0] WR_A = 3'd0, WR_B = 3'd1, WR_W = 3'd2, EXEC = 3'd3, RD_Y = 3'd4;
  logic [1:0] state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, w_q, w_d, y_q, y_d, data_q, data_d;
  logic err_q, err_d, ovf_q, ovf_d;
  logic signed [31:0] brwr_q, biwi_q, brwi_q, biwr_q;
  logic signed [17:0] pr, pi;
  logic signed [18:0] ar, ai, pr19, pi19;
  logic [15:0] xr, xi, yr, yi;
  logic sxr, sxi, syr, syi, sat;

  function automatic logic signed [17:0] rnd(input logic signed [32:0] s);
    logic signed [32:0] t;
    t = s + (ROUND != 0 ? 33'sd16384 : 33'sd0);
    return 18'(t >>> 15);
  endfunction

  // returns {saturated, value}
  function automatic logic [16:0] sat16(input logic signed [18:0] v);
    logic signed [18:0] s;
    s = SCALE != 0 ? v >>> 1 : v;
    return s > 19'sd32767 ? {1'b1, 16'h7fff} : s < -19'sd32768 ? {1'b1, 16'h8000} : {1'b0, s[15:0]};
  endfunction

  assign pr = rnd($signed({brwr_q[31], brwr_q}) - $signed({biwi_q[31], biwi_q}));
  assign pi = rnd($signed({brwi_q[31], brwi_q}) + $signed({biwr_q[31], biwr_q}));
  assign ar = {{3{a_q[31]}}, a_q[31:16]};
  assign ai = {{3{a_q[15]}}, a_q[15:0]};
  assign pr19 = {pr[17], pr};
  assign pi19 = {pi[17], pi};
  assign {sxr, xr} = sat16(ar + pr19);
  assign {sxi, xi} = sat16(ai + pi19);
  assign {syr, yr} = sat16(ar - pr19);
  assign {syi, yi} = sat16(ai - pi19);
  assign sat = sxr | sxi | syr | syi;

  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    w_d = w_q;
    y_d = y_q;
    data_d = data_q;
    err_d = err_q;
`ifdef FFT_BFLY_OVF_STICKY_EN
    ovf_d = ovf_q;
`else
    ovf_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = req_op == EXEC ? MUL : RESP;
        a_d = req_op == WR_A ? req_data : a_q;
        b_d = req_op == WR_B ? req_data : b_q;
        w_d = req_op == WR_W ? req_data : w_q;
        data_d = req_op == RD_Y ? y_q : 32'h0;
        err_d = req_op > RD_Y;
`ifdef FFT_BFLY_OVF_STICKY_EN
        ovf_d = (req_op == WR_W && req_data == 32'h0) ? 1'b0 : ovf_q;
`endif
      end
      MUL: state_d = ADD;
      ADD: begin
        state_d = RESP;
        y_d = {yr, yi};
        data_d = {xr, xi};
        err_d = 1'b0;
        ovf_d = ovf_d | sat;
      end
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      w_q <= '0;
      y_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      brwr_q <= '0;
      biwi_q <= '0;
      brwi_q <= '0;
      biwr_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      w_q <= w_d;
      y_q <= y_d;
      data_q <= data_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      brwr_q <= $signed(b_q[31:16]) * $signed(w_q[31:16]);
      biwi_q <= $signed(b_q[15:0]) * $signed(w_q[15:0]);
      brwi_q <= $signed(b_q[31:16]) * $signed(w_q[15:0]);
      biwr_q <= $signed(b_q[15:0]) * $signed(w_q[31:16]);
    end
  end

  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = data_q;
  assign rsp_err = err_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_fft_bfly_resp.sv
// tb_fft_bfly_resp: scoreboard bench driving a SCALE=0 and a SCALE=1 instance in lockstep.
module tb_fft_bfly_resp;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic [31:0] req_data = 32'h0;
  logic req_ready0, rsp_valid0, rsp_err0, ovf0, req_ready1, rsp_valid1, rsp_err1, ovf1;
  logic [31:0] rsp_data0, rsp_data1;
  logic ovf0_r, ovf1_r, ovf0_a, ovf1_a;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic err;
    logic [7:0] lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fft_bfly_resp #(.SCALE(0), .ROUND(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0), .req_op(req_op),
    .req_data(req_data), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
    .rsp_err(rsp_err0), .ovf(ovf0));
  fft_bfly_resp #(.SCALE(1), .ROUND(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1), .req_op(req_op),
    .req_data(req_data), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
    .rsp_err(rsp_err1), .ovf(ovf1));

  task automatic txn(input logic [2:0] op, input logic [31:0] d, input logic [31:0] e0,
                     input logic [31:0] e1, input logic e_err, input int lat);
    exp_t e;
    int n;
    @(negedge clk);
    checks++;
    if ({req_ready0, req_ready1} !== 2'b11) begin
      failures++;
      $display("FAIL ready_before op=%0d: got %b%b want 11", op, req_ready0, req_ready1);
    end
    req_valid = 1'b1;
    req_op = op;
    req_data = d;
    sb.push_back('{d0: e0, d1: e1, err: e_err, lat: 8'(lat)});
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 1;
    while (rsp_valid0 !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    ovf0_r = ovf0;
    ovf1_r = ovf1;
    e = sb.pop_front();
    checks++;
    if (n !== int'(e.lat)) begin
      failures++;
      $display("FAIL latency op=%0d: got %0d edges want %0d", op, n, e.lat);
    end
    checks++;
    if (rsp_data0 !== e.d0) begin
      failures++;
      $display("FAIL data_s0 op=%0d: got %h want %h", op, rsp_data0, e.d0);
    end
    checks++;
    if (rsp_data1 !== e.d1) begin
      failures++;
      $display("FAIL data_s1 op=%0d: got %h want %h", op, rsp_data1, e.d1);
    end
    checks++;
    if ({rsp_err0, rsp_err1, rsp_valid1} !== {e.err, e.err, 1'b1}) begin
      failures++;
      $display("FAIL err_valid op=%0d: got %b%b%b want %b%b1", op, rsp_err0, rsp_err1, rsp_valid1, e.err, e.err);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid0, rsp_valid1, req_ready0, req_ready1} !== 4'b0011) begin
      failures++;
      $display("FAIL after_handshake op=%0d: got %b%b%b%b want 0011", op, rsp_valid0, rsp_valid1, req_ready0, req_ready1);
    end
    ovf0_a = ovf0;
    ovf1_a = ovf1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, ovf0, ovf1} !== 8'b11000000
        || rsp_data0 !== 32'h0 || rsp_data1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got rr=%b%b rv=%b%b err=%b%b ovf=%b%b d=%h/%h want rr=11 others 0",
               req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, ovf0, ovf1, rsp_data0, rsp_data1);
    end
    @(negedge clk) rst = 1'b1;
    txn(3'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1);
  endtask

  task automatic test_scale_identity;
    txn(3'd0, 32'h2000_0000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd1, 32'h2000_0000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd2, 32'h7FFF_0000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd3, 32'h0, 32'h4000_0000, 32'h2000_0000, 1'b0, 3);
    checks++;
    if ({ovf0_r, ovf1_r} !== 2'b00) begin
      failures++;
      $display("FAIL identity_ovf: got %b%b want 00", ovf0_r, ovf1_r);
    end
    txn(3'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1);
  endtask

  task automatic test_twiddle;
    txn(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd1, 32'h2000_1000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd2, 32'h0000_8000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd3, 32'h0, 32'h1000_E000, 32'h0800_F000, 1'b0, 3);
    txn(3'd4, 32'h0, 32'hF000_2000, 32'hF800_1000, 1'b0, 1);
    txn(3'd3, 32'h0, 32'h1000_E000, 32'h0800_F000, 1'b0, 3);
  endtask

  task automatic test_saturation;
    txn(3'd0, 32'h7FFF_0000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd1, 32'h7FFF_0000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd2, 32'h7FFF_0000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd3, 32'h0, 32'h7FFF_0000, 32'h7FFE_0000, 1'b0, 3);
    checks++;
    if ({ovf0_r, ovf1_r} !== 2'b10) begin
      failures++;
      $display("FAIL sat_ovf_first: got %b%b want 10", ovf0_r, ovf1_r);
    end
`ifdef FFT_BFLY_OVF_STICKY_EN
    checks++;
    if ({ovf0_a, ovf1_a} !== 2'b10) begin
      failures++;
      $display("FAIL sat_ovf_sticky: got %b%b want 10", ovf0_a, ovf1_a);
    end
    txn(3'd4, 32'h0, 32'h0001_0000, 32'h0, 1'b0, 1);
    checks++;
    if (ovf0_a !== 1'b1) begin
      failures++;
      $display("FAIL ovf_persist: got %b want 1", ovf0_a);
    end
`else
    checks++;
    if ({ovf0_a, ovf1_a} !== 2'b00) begin
      failures++;
      $display("FAIL sat_ovf_pulse: got %b%b want 00", ovf0_a, ovf1_a);
    end
    txn(3'd4, 32'h0, 32'h0001_0000, 32'h0, 1'b0, 1);
`endif
    txn(3'd2, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    checks++;
    if ({ovf0_a, ovf1_a} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_clear: got %b%b want 00", ovf0_a, ovf1_a);
    end
  endtask

  task automatic test_illegal;
    txn(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd1, 32'h2000_1000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd2, 32'h0000_8000, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd7, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1);
    txn(3'd5, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1);
    txn(3'd3, 32'h0, 32'h1000_E000, 32'h0800_F000, 1'b0, 3);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd4;
    sb.push_back('{d0: 32'hF000_2000, d1: 32'hF800_1000, err: 1'b0, lat: 8'd1});
    @(posedge clk);
    #1 req_op = 3'd0;
    req_data = 32'h2000_0000;
    e = sb.pop_front();
    repeat (5) begin
      @(posedge clk);
      #1 checks++;
      if ({rsp_valid0, rsp_valid1, req_ready0, req_ready1} !== 4'b1100 || rsp_data0 !== e.d0 || rsp_data1 !== e.d1) begin
        failures++;
        $display("FAIL held_resp: got v=%b%b rr=%b%b d=%h/%h want v=11 rr=00 d=%h/%h",
                 rsp_valid0, rsp_valid1, req_ready0, req_ready1, rsp_data0, rsp_data1, e.d0, e.d1);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid0, req_ready0} !== 2'b01) begin
      failures++;
      $display("FAIL post_hs: got v=%b rr=%b want v=0 rr=1", rsp_valid0, req_ready0);
    end
    sb.push_back('{d0: 32'h0, d1: 32'h0, err: 1'b0, lat: 8'd1});
    @(posedge clk);
    #1 req_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({rsp_valid0, req_ready0} !== 2'b10 || rsp_data0 !== e.d0 || rsp_err0 !== e.err) begin
      failures++;
      $display("FAIL queued_accept: got v=%b rr=%b d=%h err=%b want v=1 rr=0 d=%h err=%b",
               rsp_valid0, req_ready0, rsp_data0, rsp_err0, e.d0, e.err);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    txn(3'd3, 32'h0, 32'h3000_E000, 32'h1800_F000, 1'b0, 3);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 checks++;
    if ({rsp_valid0, rsp_valid1, req_ready0, req_ready1, ovf0} !== 5'b00110) begin
      failures++;
      $display("FAIL reset_mid: got v=%b%b rr=%b%b ovf=%b want v=00 rr=11 ovf=0",
               rsp_valid0, rsp_valid1, req_ready0, req_ready1, ovf0);
    end
    @(negedge clk) rst = 1'b1;
    txn(3'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1);
    txn(3'd3, 32'h0, 32'h0, 32'h0, 1'b0, 3);
  endtask

  initial begin
    test_reset();
    test_scale_identity();
    test_twiddle();
    test_saturation();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
